pipe_multiply: RTL

PIPE_MULTIPLY -- requirements
Module: pipe_multiply

---
 rtl/pipe_multiply_pkg.sv | 22 ++
 rtl/pipe_multiply_round_shift.sv | 29 ++
 rtl/pipe_multiply.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_multiply_pkg.sv
// r22sdf_pkg: shared constants and helpers for the complex twiddle multiplier.
// MULT_LATENCY is the number of advancing cycles from input to output transfer.
package r22sdf_pkg;

  localparam int MULT_LATENCY = 3;

  // Half of one output LSB for a Q1.(tw-1) twiddle: 2^(tw-2).
  function automatic logic signed [63:0] round_offset(input int tw);
    return 64'sd1 <<< (tw - 32'sd2);
  endfunction

  // Largest value representable in a w-bit two's complement word.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 32'sd1));
  endfunction

endpackage

// File: rtl/pipe_multiply_round_shift.sv
// round_shift: rounds one full-precision product half up and drops the
// TW_WIDTH-1 fractional twiddle bits, giving a WIDTH+1-bit signed result.
module round_shift
  import r22sdf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic signed [WIDTH+TW_WIDTH-1:0] prod,
  output logic signed [WIDTH:0]            res
);

  localparam int PW = WIDTH + TW_WIDTH;
  localparam logic signed [63:0] RND_FULL = round_offset(TW_WIDTH);
  localparam logic signed [PW-1:0] RND = RND_FULL[PW-1:0];

  logic signed [PW-1:0] biased_s;

  // Bias by half an LSB; |prod| <= 2^(PW-2) so this cannot overflow PW bits.
  always_comb begin
    biased_s = prod + RND;
  end

  // Arithmetic shift floors the biased value; the discarded top bits are sign copies.
  always_comb begin
    res = (WIDTH+1)'(biased_s >>> (TW_WIDTH - 32'sd1));
  end

endmodule

// File: rtl/pipe_multiply.sv
// pipe_multiply: 3-stage complex multiplier m = a * b with a valid/ready
// handshake, half-up rounding and a sticky overflow flag.
// Build option: define PIPE_MULTIPLY_SAT_EN to clamp overflowing components;
// otherwise they wrap to the low WIDTH bits. ovf behaves the same either way.
module pipe_multiply
  import r22sdf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       di_en,
  output logic                       di_ready,
  input  logic signed [WIDTH-1:0]    a_re,
  input  logic signed [WIDTH-1:0]    a_im,
  input  logic signed [TW_WIDTH-1:0] b_re,
  input  logic signed [TW_WIDTH-1:0] b_im,
  output logic                       do_en,
  input  logic                       do_ready,
  output logic signed [WIDTH-1:0]    m_re,
  output logic signed [WIDTH-1:0]    m_im,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int PW = WIDTH + TW_WIDTH;
  // One guard bit above the WIDTH+1 rounded terms keeps the -1 * -1 corner detectable.
  localparam int SW = WIDTH + 2;
  localparam logic signed [63:0] MAX_FULL = sat_max(WIDTH);
  localparam logic signed [63:0] MIN_FULL = sat_min(WIDTH);
  localparam logic signed [SW-1:0] SUM_MAX = MAX_FULL[SW-1:0];
  localparam logic signed [SW-1:0] SUM_MIN = MIN_FULL[SW-1:0];
`ifdef PIPE_MULTIPLY_SAT_EN
  localparam logic signed [WIDTH-1:0] OUT_MAX = MAX_FULL[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] OUT_MIN = MIN_FULL[WIDTH-1:0];
`endif

  logic                       advance_s;
  logic                       s1_v_r;
  logic signed [WIDTH-1:0]    s1_a_re_r, s1_a_im_r;
  logic signed [TW_WIDTH-1:0] s1_b_re_r, s1_b_im_r;
  logic                       s2_v_r;
  logic signed [PW-1:0]       p_rr_r, p_ii_r, p_ri_r, p_ir_r;
  logic signed [WIDTH:0]      rr_s, ii_s, ri_s, ir_s;
  logic signed [SW-1:0]       re_sum_s, im_sum_s;
  logic                       re_ovf_s, im_ovf_s;
  logic signed [WIDTH-1:0]    re_res_s, im_res_s;

  // Whole pipeline moves together unless a valid output is being held back.
  always_comb begin
    advance_s = !do_en || do_ready;
    di_ready  = advance_s;
  end

  // S1: capture operands and their valid bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v_r    <= 1'b0;
      s1_a_re_r <= '0;
      s1_a_im_r <= '0;
      s1_b_re_r <= '0;
      s1_b_im_r <= '0;
    end else if (advance_s) begin
      s1_v_r    <= di_en;
      s1_a_re_r <= a_re;
      s1_a_im_r <= a_im;
      s1_b_re_r <= b_re;
      s1_b_im_r <= b_im;
    end
  end

  // S2: register the four full-precision signed partial products.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_v_r <= 1'b0;
      p_rr_r <= '0;
      p_ii_r <= '0;
      p_ri_r <= '0;
      p_ir_r <= '0;
    end else if (advance_s) begin
      s2_v_r <= s1_v_r;
      p_rr_r <= s1_a_re_r * s1_b_re_r;
      p_ii_r <= s1_a_im_r * s1_b_im_r;
      p_ri_r <= s1_a_re_r * s1_b_im_r;
      p_ir_r <= s1_a_im_r * s1_b_re_r;
    end
  end

  round_shift #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_rs_rr (.prod(p_rr_r), .res(rr_s));
  round_shift #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_rs_ii (.prod(p_ii_r), .res(ii_s));
  round_shift #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_rs_ri (.prod(p_ri_r), .res(ri_s));
  round_shift #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) u_rs_ir (.prod(p_ir_r), .res(ir_s));

  // Combine the rounded terms and flag any component outside the WIDTH-bit range.
  always_comb begin
    re_sum_s = {rr_s[WIDTH], rr_s} - {ii_s[WIDTH], ii_s};
    im_sum_s = {ri_s[WIDTH], ri_s} + {ir_s[WIDTH], ir_s};
    re_ovf_s = (re_sum_s > SUM_MAX) || (re_sum_s < SUM_MIN);
    im_ovf_s = (im_sum_s > SUM_MAX) || (im_sum_s < SUM_MIN);
  end

  // Reduce each component to WIDTH bits: clamp or wrap depending on the build.
  always_comb begin
    re_res_s = re_sum_s[WIDTH-1:0];
    im_res_s = im_sum_s[WIDTH-1:0];
`ifdef PIPE_MULTIPLY_SAT_EN
    if (re_ovf_s) begin
      re_res_s = re_sum_s[SW-1] ? OUT_MIN : OUT_MAX;
    end else begin
      re_res_s = re_sum_s[WIDTH-1:0];
    end
    if (im_ovf_s) begin
      im_res_s = im_sum_s[SW-1] ? OUT_MIN : OUT_MAX;
    end else begin
      im_res_s = im_sum_s[WIDTH-1:0];
    end
`endif
  end

  // S3: output register; data only changes when a valid sample arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      do_en <= 1'b0;
      m_re  <= '0;
      m_im  <= '0;
    end else if (advance_s) begin
      do_en <= s2_v_r;
      if (s2_v_r) begin
        m_re <= re_res_s;
        m_im <= im_res_s;
      end
    end
  end

  // Sticky overflow: a new overflowing S3 load beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (advance_s && s2_v_r && (re_ovf_s || im_ovf_s)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule
